// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access-size encoding and FSM states.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_NONE = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/load_store_align.sv
// Lane handling for data-memory accesses: misalignment detection, byte enables,
// store-data replication and load-data extraction with sign/zero extension.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    input  logic        ld_uns,
    output logic        misalign,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half-word out of the read word.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Decode size and offset into lanes, enables and the extended load value.
    always_comb begin
        misalign = 1'b0;
        be       = 4'b0000;
        wdata    = st_data;
        ld_data  = rdata;
        case (size)
            MEM_BYTE: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{~ld_uns & byte_sel[7]}}, byte_sel};
            end
            MEM_HALF: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{st_data[15:0]}};
                ld_data  = {{16{~ld_uns & half_sel[15]}}, half_sel};
            end
            MEM_WORD: begin
                misalign = (addr_lo != 2'b00);
                be       = 4'b1111;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the req/ack data bus, stalls upstream while
// an access is outstanding, and holds the MEM/WB register.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | no access outstanding; a new aligned op may request the bus
//  ACCESS | request held, waiting for ack or for the timeout to expire
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_aluo,
    input  logic [31:0] i_rv2,
    input  logic [31:0] i_pc_plus_4,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_mem_r,
    input  logic [1:0]  i_mem_w,
    input  logic        i_mem_t_reg,
    input  logic        i_rd_in,
    input  logic        i_ld_uns,
    input  logic        i_reg_w,
    input  logic        i_flush,
    output logic        o_dm_req,
    output logic        o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    output logic [3:0]  o_dm_be,
    input  logic        i_dm_ack,
    input  logic [31:0] i_dm_rdata,
    output logic        o_stall,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_reg_w,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic        is_store;
    logic        memop;
    logic [1:0]  size;
    logic        misalign;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld_data;
    logic [31:0] wb_sel;
    logic        timeout_hit;
    logic        abort;

    logic [31:0] wb_data_nxt;
    logic [4:0]  wb_rd_nxt;
    logic        wb_reg_w_nxt;
    logic        misalign_nxt;
    logic        bus_err_nxt;

    load_store_align u_align (
        .addr_lo  (i_aluo[1:0]),
        .size     (size),
        .st_data  (i_rv2),
        .rdata    (i_dm_rdata),
        .ld_uns   (i_ld_uns),
        .misalign (misalign),
        .be       (be),
        .wdata    (wdata),
        .ld_data  (ld_data)
    );

    // Classify the op in MEM and drive the bus straight from the stage inputs.
    // A store overrides a simultaneous load, so its size governs the lanes.
    always_comb begin
        is_store   = (i_mem_w != MEM_NONE);
        memop      = is_store | (i_mem_r != MEM_NONE);
        size       = is_store ? i_mem_w : i_mem_r;
        o_dm_req   = ((state == IDLE) & memop & ~misalign & ~i_flush) | (state == ACCESS);
        o_stall    = o_dm_req & ~i_dm_ack;
        o_dm_we    = o_dm_req & is_store;
        o_dm_addr  = {i_aluo[31:2], 2'b00};
        o_dm_wdata = wdata;
        o_dm_be    = be;
        wb_sel     = i_rd_in ? i_pc_plus_4 : (i_mem_t_reg ? ld_data : i_aluo);
        // cnt sits at 0 in IDLE, so the first request cycle counts as wait cycle 0
        // and the request stays up for exactly TIMEOUT cycles before aborting.
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
        abort       = o_dm_req & ~i_dm_ack & timeout_hit;
    end

    // Next-state, wait counter and MEM/WB capture; default is a bubble into WB.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = '0;
        wb_data_nxt  = '0;
        wb_rd_nxt    = '0;
        wb_reg_w_nxt = 1'b0;
        misalign_nxt = 1'b0;
        bus_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_flush) begin
                    state_nxt = IDLE;
                end else if (!memop) begin
                    wb_data_nxt  = wb_sel;
                    wb_rd_nxt    = i_rd;
                    wb_reg_w_nxt = i_reg_w;
                end else if (misalign) begin
                    wb_rd_nxt    = i_rd;
                    misalign_nxt = 1'b1;
                end else if (i_dm_ack) begin
                    wb_data_nxt  = wb_sel;
                    wb_rd_nxt    = i_rd;
                    wb_reg_w_nxt = i_reg_w & ~is_store;
                end else if (abort) begin
                    wb_rd_nxt   = i_rd;
                    bus_err_nxt = 1'b1;
                end else begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CW'(1);
                end
            end
            ACCESS: begin
                if (i_dm_ack) begin
                    state_nxt    = IDLE;
                    wb_data_nxt  = wb_sel;
                    wb_rd_nxt    = i_rd;
                    wb_reg_w_nxt = i_reg_w & ~is_store;
                end else if (abort) begin
                    state_nxt   = IDLE;
                    wb_rd_nxt   = i_rd;
                    bus_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            o_wb_data  <= '0;
            o_wb_rd    <= '0;
            o_wb_reg_w <= 1'b0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            o_wb_data  <= wb_data_nxt;
            o_wb_rd    <= wb_rd_nxt;
            o_wb_reg_w <= wb_reg_w_nxt;
            o_misalign <= misalign_nxt;
            o_bus_err  <= bus_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases plus randomized ops against a
// behavioural model; WB and bus monitors pop expectations as outputs appear.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_aluo, i_rv2, i_pc_plus_4, i_dm_rdata;
    logic [4:0]  i_rd;
    logic [1:0]  i_mem_r, i_mem_w;
    logic        i_mem_t_reg, i_rd_in, i_ld_uns, i_reg_w, i_flush, i_dm_ack;
    logic        o_dm_req, o_dm_we, o_stall, o_wb_reg_w, o_misalign, o_bus_err;
    logic [31:0] o_dm_addr, o_dm_wdata, o_wb_data;
    logic [3:0]  o_dm_be;
    logic [4:0]  o_wb_rd;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_aluo(i_aluo), .i_rv2(i_rv2), .i_pc_plus_4(i_pc_plus_4),
        .i_rd(i_rd), .i_mem_r(i_mem_r), .i_mem_w(i_mem_w), .i_mem_t_reg(i_mem_t_reg),
        .i_rd_in(i_rd_in), .i_ld_uns(i_ld_uns), .i_reg_w(i_reg_w), .i_flush(i_flush),
        .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata),
        .o_dm_be(o_dm_be), .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata), .o_stall(o_stall),
        .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_wb_reg_w(o_wb_reg_w),
        .o_misalign(o_misalign), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_w;
        logic        mis;
        logic        err;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        i_aluo = '0; i_rv2 = '0; i_pc_plus_4 = '0; i_rd = '0;
        i_mem_r = 2'b11; i_mem_w = 2'b11; i_mem_t_reg = 0; i_rd_in = 0;
        i_ld_uns = 0; i_reg_w = 0; i_flush = 0; i_dm_ack = 0; i_dm_rdata = '0;
    endtask

    // WB monitor: every visible writeback/flag must match the next expectation.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && (o_wb_reg_w || o_misalign || o_bus_err)) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", {29'b0, o_wb_reg_w, o_misalign, o_bus_err}, 32'd0);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_flags", {29'b0, o_wb_reg_w, o_misalign, o_bus_err},
                          {29'b0, e.reg_w, e.mis, e.err});
                    if (e.reg_w) begin
                        check("wb_data", o_wb_data, e.data);
                        check("wb_rd", {27'b0, o_wb_rd}, {27'b0, e.rd});
                    end
                end
            end
        end
    end

    // Bus monitor: compares address/enables/data at the start of each transaction.
    initial begin
        bus_t b;
        logic prev_req = 0, prev_ack = 0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                prev_req = 0; prev_ack = 0;
            end else begin
                if (o_dm_req && (!prev_req || prev_ack || o_bus_err)) begin
                    if (bus_q.size() == 0) begin
                        check("bus_unexpected", 32'd1, 32'd0);
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_addr", o_dm_addr, b.addr);
                        check("bus_be", {28'b0, o_dm_be}, {28'b0, b.be});
                        check("bus_we", {31'b0, o_dm_we}, {31'b0, b.we});
                        if (b.we) check("bus_wdata", o_dm_wdata, b.wdata);
                    end
                end
                prev_req = o_dm_req;
                prev_ack = i_dm_ack;
            end
        end
    end

    // One op through the stage. lat = cycles from first req to ack; -1 = never ack.
    task automatic run_op(input string tag, input logic [31:0] aluo, input logic [31:0] rv2,
                          input logic [31:0] pc4, input logic [31:0] rdata, input logic [4:0] rd,
                          input logic [1:0] mr, input logic [1:0] mw, input logic mt,
                          input logic rdin, input logic uns, input logic rw, input logic fl,
                          input int lat);
        logic        st, memop, mis;
        logic [1:0]  sz, off;
        logic [31:0] v, sel;
        bus_t        b;
        wb_t         w;
        int          exp_req, exp_stall, nreq, nstall;
        bit          done;

        st = (mw != 2'b11); memop = st || (mr != 2'b11); sz = st ? mw : mr; off = aluo[1:0];
        mis = memop && ((sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0));
        v = rdata;
        if (sz == 2'd0) begin
            v = (rdata >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rdata >> (16 * off[1])) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        sel = rdin ? pc4 : (mt ? v : aluo);

        exp_req = 0; exp_stall = 0;
        w = '{data: sel, rd: rd, reg_w: 1'b0, mis: 1'b0, err: 1'b0};
        if (fl) begin
        end else if (!memop) begin
            if (rw) begin w.reg_w = 1; wb_q.push_back(w); end
        end else if (mis) begin
            w.mis = 1; wb_q.push_back(w);
        end else begin
            b.addr = aluo & 32'hFFFF_FFFC;
            b.we   = st;
            b.be   = (sz == 2'd0) ? (4'b0001 << off) : (sz == 2'd1) ? (4'b0011 << (2 * off[1])) : 4'b1111;
            b.wdata = (sz == 2'd0) ? 32'(rv2[7:0]) * 32'h01010101 :
                      (sz == 2'd1) ? 32'(rv2[15:0]) * 32'h00010001 : rv2;
            bus_q.push_back(b);
            if (lat < 0) begin
                exp_req = TO; exp_stall = TO;
                w.err = 1; wb_q.push_back(w);
            end else begin
                exp_req = lat + 1; exp_stall = lat;
                if (rw && !st) begin w.reg_w = 1; wb_q.push_back(w); end
            end
        end

        @(negedge clk);
        i_aluo = aluo; i_rv2 = rv2; i_pc_plus_4 = pc4; i_dm_rdata = rdata; i_rd = rd;
        i_mem_r = mr; i_mem_w = mw; i_mem_t_reg = mt; i_rd_in = rdin; i_ld_uns = uns;
        i_reg_w = rw; i_flush = fl; i_dm_ack = (lat == 0);
        nreq = 0; nstall = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                i_dm_ack = (c == lat);
            end
            #1;
            if (o_dm_req) nreq++;
            if (o_stall) nstall++;
            done = !o_stall || (lat < 0 && nreq >= TO);
            @(posedge clk);
        end
        if (!done) check({tag, "_cycle_budget"}, 32'd0, 32'd1);
        check({tag, "_req_cycles"}, nreq, exp_req);
        check({tag, "_stall_cycles"}, nstall, exp_stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r, lat;
        logic [31:0] a;
        logic [1:0]  mr, mw;
        logic        mt;

        rst = 1; set_idle();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_req", {31'b0, o_dm_req}, 32'd0);
        check("reset_wb", {o_wb_data[31:8], o_wb_data[7:0] | {3'b0, o_wb_rd}}, 32'd0);
        check("reset_flags", {29'b0, o_wb_reg_w, o_misalign, o_bus_err}, 32'd0);
        rst = 0;

        run_op("st_word",   32'h104, 32'hDEADBEEF, 32'h0, 32'h0,        5'd9, 2'b11, 2'b10, 0, 0, 0, 1, 0, 2);
        run_op("ld_byte_u", 32'h203, 32'h0, 32'h0, 32'h80112233, 5'd3, 2'b00, 2'b11, 1, 0, 1, 1, 0, 0);
        run_op("ld_byte_s", 32'h203, 32'h0, 32'h0, 32'h80112233, 5'd4, 2'b00, 2'b11, 1, 0, 0, 1, 0, 0);
        run_op("st_half",   32'h12,  32'h0000ABCD, 32'h0, 32'h0,     5'd1, 2'b11, 2'b01, 0, 0, 0, 0, 0, 1);
        run_op("ld_misal",  32'h102, 32'h0, 32'h0, 32'h12345678,  5'd6, 2'b10, 2'b11, 1, 0, 0, 1, 0, 0);
        run_op("ld_tmo",    32'h300, 32'h0, 32'h0, 32'h0,         5'd8, 2'b10, 2'b11, 1, 0, 0, 1, 0, -1);
        run_op("alu",       32'h55,  32'h0, 32'h0, 32'h0,         5'd7, 2'b11, 2'b11, 0, 0, 0, 1, 0, 0);
        run_op("ld_half_s", 32'h402, 32'h0, 32'h0, 32'h9ABC1234, 5'd10, 2'b01, 2'b11, 1, 0, 0, 1, 0, 3);
        run_op("link",      32'h77,  32'h0, 32'h1004, 32'h0,      5'd1, 2'b11, 2'b11, 0, 1, 0, 1, 0, 0);
        run_op("st_and_ld", 32'h20,  32'hCAFEF00D, 32'h0, 32'h0,  5'd2, 2'b10, 2'b10, 1, 0, 0, 1, 0, 1);
        run_op("flush_ld",  32'h40,  32'h0, 32'h0, 32'h0,         5'd5, 2'b10, 2'b11, 1, 0, 0, 1, 1, 0);
        run_op("st_byte",   32'h501, 32'h000000A5, 32'h0, 32'h0,  5'd0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);

        // Reset while a load waits in ACCESS, then a stray ack after reset.
        bus_q.push_back('{addr: 32'h60, be: 4'hF, we: 1'b0, wdata: 32'h0});
        @(negedge clk);
        set_idle(); i_aluo = 32'h60; i_mem_r = 2'b10; i_reg_w = 1; i_mem_t_reg = 1; i_rd = 5'd12;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1; set_idle();
        @(posedge clk); #1;
        check("rst_mid_req", {31'b0, o_dm_req}, 32'd0);
        check("rst_mid_stall", {31'b0, o_stall}, 32'd0);
        check("rst_mid_wb", o_wb_data | {27'b0, o_wb_rd}, 32'd0);
        check("rst_mid_flags", {29'b0, o_wb_reg_w, o_misalign, o_bus_err}, 32'd0);
        @(negedge clk);
        rst = 0; i_dm_ack = 1;
        #1;
        check("late_ack_req", {31'b0, o_dm_req}, 32'd0);
        @(negedge clk);
        i_dm_ack = 0;

        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 9);
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            mr = 2'b11; mw = 2'b11; mt = 0;
            if (r >= 3 && r <= 5) begin
                mr = 2'($urandom_range(0, 2)); mt = ($urandom_range(0, 3) != 0);
            end else if (r == 6 || r == 7) begin
                mw = 2'($urandom_range(0, 2));
            end else if (r == 8) begin
                mr = 2'($urandom_range(0, 2)); mw = 2'($urandom_range(0, 2)); mt = 1;
            end
            lat = $urandom_range(0, 9);
            lat = (lat == 9) ? -1 : lat % 4;
            run_op("rand", a, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), mr, mw, mt,
                   ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), lat);
        end

        @(negedge clk);
        set_idle();
        repeat (4) @(negedge clk);
        check("wb_queue_drained", wb_q.size(), 32'd0);
        check("bus_queue_drained", bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
